jtag_host: RTL and testbench

- Host-side JTAG driver that generates TMS/TDI to steer a target TAP controller and performs complete IR and DR scans.
- Keeps a shadow copy of the target's 16-state TAP state, using the same 4-bit encoding as the target.
- Sits between a command/response interface and the JTAG pins.
- Advances exactly one TCK per CLK cycle: the target samples tms/tdi on the same CLK edge as the host.

---
 rtl/jtag_pkg.sv | 41 ++++
 rtl/jtag_host_tap_next_state.sv | 34 +++
 rtl/jtag_host.sv | 175 +++++++++++++++++
 tb/tb_jtag_host.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG host: TAP state encoding, command opcodes
// and the host sequencer states.
package jtag_pkg;

    localparam logic [3:0] TLR    = 4'd15;
    localparam logic [3:0] RTI    = 4'd12;
    localparam logic [3:0] SEL_DR = 4'd7;
    localparam logic [3:0] CAP_DR = 4'd6;
    localparam logic [3:0] SH_DR  = 4'd2;
    localparam logic [3:0] EX1_DR = 4'd1;
    localparam logic [3:0] PA_DR  = 4'd3;
    localparam logic [3:0] EX2_DR = 4'd0;
    localparam logic [3:0] UPD_DR = 4'd5;
    localparam logic [3:0] SEL_IR = 4'd4;
    localparam logic [3:0] CAP_IR = 4'd14;
    localparam logic [3:0] SH_IR  = 4'd10;
    localparam logic [3:0] EX1_IR = 4'd9;
    localparam logic [3:0] PA_IR  = 4'd11;
    localparam logic [3:0] EX2_IR = 4'd8;
    localparam logic [3:0] UPD_IR = 4'd13;

    // Number of tms=1 cycles that forces any TAP into TEST_LOGIC_RESET.
    localparam int INIT_TMS1_CYCLES = 5;

    typedef enum logic [1:0] {
        OP_RESET   = 2'd0,
        OP_IR_SCAN = 2'd1,
        OP_DR_SCAN = 2'd2,
        OP_IDLE    = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_READY,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_WAIT
    } host_state_e;

endpackage

// File: rtl/jtag_host_tap_next_state.sv
// Standard IEEE 1149.1 TAP transition function, shared by the host shadow
// copy and any target model so the two encodings cannot drift apart.
module tap_next_state
    import jtag_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic       i_tms,
    output logic [3:0] o_next
);

    always_comb begin
        o_next = TLR;
        case (i_state)
            TLR:    o_next = i_tms ? TLR    : RTI;
            RTI:    o_next = i_tms ? SEL_DR : RTI;
            SEL_DR: o_next = i_tms ? SEL_IR : CAP_DR;
            CAP_DR: o_next = i_tms ? EX1_DR : SH_DR;
            SH_DR:  o_next = i_tms ? EX1_DR : SH_DR;
            EX1_DR: o_next = i_tms ? UPD_DR : PA_DR;
            PA_DR:  o_next = i_tms ? EX2_DR : PA_DR;
            EX2_DR: o_next = i_tms ? UPD_DR : SH_DR;
            UPD_DR: o_next = i_tms ? SEL_DR : RTI;
            SEL_IR: o_next = i_tms ? TLR    : CAP_IR;
            CAP_IR: o_next = i_tms ? EX1_IR : SH_IR;
            SH_IR:  o_next = i_tms ? EX1_IR : SH_IR;
            EX1_IR: o_next = i_tms ? UPD_IR : PA_IR;
            PA_IR:  o_next = i_tms ? EX2_IR : PA_IR;
            EX2_IR: o_next = i_tms ? UPD_IR : SH_IR;
            UPD_IR: o_next = i_tms ? SEL_DR : RTI;
            default: o_next = TLR;
        endcase
    end

endmodule

// File: rtl/jtag_host.sv
// JTAG host: accepts RESET/IR_SCAN/DR_SCAN/IDLE commands, drives TMS/TDI one
// TCK per CLK, captures TDO during shifts and tracks the target TAP state.
module jtag_host
    import jtag_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic [3:0]         tap_state,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy
);

    localparam int IDX_W = $clog2(MAX_LEN);

    host_state_e        r_state;
    host_state_e        w_state_nxt;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_nxt;
    cmd_op_e            r_op;
    logic [LEN_W-1:0]   r_len;
    logic [MAX_LEN-1:0] r_data;
    logic [MAX_LEN-1:0] r_cap;
    logic [MAX_LEN-1:0] r_rsp_data;
    logic               r_rsp_valid;
    logic               r_active;
    logic [3:0]         r_tap;
    logic [3:0]         w_tap_nxt;
    logic [LEN_W-1:0]   w_len_clamped;
    logic [IDX_W-1:0]   w_idx;
    logic               w_accept;
    logic               w_pre_last;
    logic               w_done;

    tap_next_state u_tap_next (
        .i_state (r_tap),
        .i_tms   (tms),
        .o_next  (w_tap_nxt)
    );

    assign cmd_ready = (r_state == ST_READY);
    assign busy      = ~cmd_ready;
    assign tap_state = r_tap;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_idx     = r_cnt[IDX_W-1:0];

    always_comb begin
        if (cmd_len == '0) begin
            w_len_clamped = LEN_W'(1);
        end else if (cmd_len > LEN_W'(MAX_LEN)) begin
            w_len_clamped = LEN_W'(MAX_LEN);
        end else begin
            w_len_clamped = cmd_len;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + LEN_W'(1);
        w_pre_last  = 1'b0;
        tms         = 1'b0;
        tdi         = 1'b0;
        case (r_state)
            ST_INIT: begin
                tms = (r_cnt < LEN_W'(INIT_TMS1_CYCLES));
                if (r_cnt == LEN_W'(INIT_TMS1_CYCLES)) begin
                    w_state_nxt = ST_READY;
                    w_cnt_nxt   = '0;
                end
            end
            ST_READY: begin
                w_cnt_nxt = '0;
                if (cmd_valid) begin
                    case (cmd_op_e'(cmd_op))
                        OP_RESET:   w_state_nxt = ST_INIT;
                        OP_IR_SCAN: w_state_nxt = ST_PRE;
                        OP_DR_SCAN: w_state_nxt = ST_PRE;
                        OP_IDLE:    w_state_nxt = ST_WAIT;
                    endcase
                end
            end
            ST_PRE: begin
                // IR path needs an extra tms=1 to pass SELECT_DR into SELECT_IR.
                if (r_op == OP_IR_SCAN) begin
                    tms        = (r_cnt < LEN_W'(2));
                    w_pre_last = (r_cnt == LEN_W'(3));
                end else begin
                    tms        = (r_cnt == '0);
                    w_pre_last = (r_cnt == LEN_W'(2));
                end
                if (w_pre_last) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                tdi = r_data[w_idx];
                tms = (r_cnt == r_len - LEN_W'(1));
                if (tms) begin
                    w_state_nxt = ST_POST;
                    w_cnt_nxt   = '0;
                end
            end
            ST_POST: begin
                tms = (r_cnt == '0);
                if (r_cnt == LEN_W'(1)) begin
                    w_state_nxt = ST_READY;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT: begin
                if (r_cnt == r_len - LEN_W'(1)) begin
                    w_state_nxt = ST_READY;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
        w_done = r_active && (r_state != ST_READY) && (w_state_nxt == ST_READY);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_tap       <= TLR;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_active    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tap       <= w_tap_nxt;
            r_rsp_valid <= w_done;
            if (w_accept) begin
                r_active <= 1'b1;
            end else if (w_done) begin
                r_active <= 1'b0;
            end
            if (w_done && (r_op == OP_IR_SCAN || r_op == OP_DR_SCAN)) begin
                r_rsp_data <= r_cap;
            end
        end
    end

    // NOTE: command/capture registers carry no reset; each is loaded at accept before it is read.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_op   <= cmd_op_e'(cmd_op);
            r_len  <= w_len_clamped;
            r_data <= cmd_data;
            r_cap  <= '0;
        end else if (r_state == ST_SHIFT && (r_tap == SH_DR || r_tap == SH_IR)) begin
            r_cap[w_idx] <= tdo;
        end
    end

endmodule

// File: tb/tb_jtag_host.sv
// Self-checking bench for jtag_host: a bench-side target TAP with IR/DR,
// directed scenarios, then randomized commands against a stream-level model.
module tb_jtag_host;
    import jtag_pkg::*;

    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;

    // Target TAP transition table, indexed by state, one table per tms value.
    localparam logic [3:0] NXT0 [16] = '{4'd2, 4'd3, 4'd2, 4'd3, 4'd14, 4'd12, 4'd2, 4'd6,
                                         4'd10, 4'd11, 4'd10, 4'd11, 4'd12, 4'd12, 4'd10, 4'd12};
    localparam logic [3:0] NXT1 [16] = '{4'd5, 4'd5, 4'd1, 4'd0, 4'd15, 4'd7, 4'd1, 4'd4,
                                         4'd13, 4'd13, 4'd9, 4'd8, 4'd7, 4'd7, 4'd9, 4'd15};

    logic               CLK = 1'b0;
    logic               RESET_N;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               tms;
    logic               tdi;
    logic               tdo;
    logic [3:0]         tap_state;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               busy;

    int n_cmp = 0;
    int n_mis = 0;

    // Bench-side target TAP
    logic [3:0]  tgt_tap = 4'($urandom_range(0, 15));
    logic [31:0] dr, dr_sr, ir;
    logic [3:0]  ir_sr;
    int          dr_len = 8;
    logic        load_req = 1'b0;
    logic [31:0] dr_init = '0;

    logic [31:0] exp_rsp = '0;
    logic [31:0] exp_dr  = '0;
    logic [31:0] exp_ir  = '0;

    jtag_host #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tap_state (tap_state),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    // tdo idles high so any capture outside a shift state shows up as stray ones.
    assign tdo = (tgt_tap == SH_DR) ? dr_sr[0] : (tgt_tap == SH_IR) ? ir_sr[0] : 1'b1;

    always @(posedge CLK) begin
        if (load_req) dr <= dr_init;
        case (tgt_tap)
            CAP_DR: dr_sr <= dr;
            SH_DR:  dr_sr <= (dr_sr >> 1) | ({31'd0, tdi} << (dr_len - 1));
            UPD_DR: dr    <= dr_sr;
            CAP_IR: ir_sr <= 4'b0001;
            SH_IR:  ir_sr <= {tdi, ir_sr[3:1]};
            UPD_IR: ir    <= {28'd0, ir_sr};
            default: ;
        endcase
        tgt_tap <= (tms === 1'b0) ? NXT0[tgt_tap] : NXT1[tgt_tap];
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_len(input int len);
        return (len == 0) ? 1 : (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    // Expected busy length and per-cycle tms/tdi, bit k = k-th busy cycle.
    function automatic void expect_seq(input logic [1:0] op, input int n, input logic [31:0] data,
                                       output int eb, output logic [63:0] et, output logic [63:0] ed);
        int k;
        et = '0;
        ed = '0;
        if (op == OP_RESET) begin
            et = 64'b011111;
            eb = 6;
        end else if (op == OP_IDLE) begin
            eb = n;
        end else begin
            et[0] = 1'b1;
            if (op == OP_IR_SCAN) begin
                et[1] = 1'b1;
                k = 4;
            end else begin
                k = 3;
            end
            for (int i = 0; i < n; i++) ed[k + i] = data[i];
            et[k + n - 1] = 1'b1;
            et[k + n]     = 1'b1;
            eb = k + n + 2;
        end
    endfunction

    // A scan is one bit stream: register contents come out first, then tdi bits follow.
    function automatic void scan_model(input logic [31:0] old, input int len_reg, input logic [31:0] din,
                                       input int n, output logic [31:0] rsp, output logic [31:0] new_reg);
        logic [63:0] stream;
        stream  = ({32'd0, din} << len_reg) | {32'd0, old};
        rsp     = 32'(stream & ((64'd1 << n) - 64'd1));
        new_reg = 32'((stream >> n) & ((64'd1 << len_reg) - 64'd1));
    endfunction

    task automatic preload_dr(input int len_reg, input logic [31:0] v);
        dr_len   = len_reg;
        dr_init  = 32'({32'd0, v} & ((64'd1 << len_reg) - 64'd1));
        exp_dr   = dr_init;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] op, input int len, input logic [31:0] data, input int exp_busy,
                          output int busy_n, output logic [63:0] tms_v, output logic [63:0] tdi_v);
        int guard = 0;
        busy_n    = 0;
        tms_v     = '0;
        tdi_v     = '0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        cmd_data  = data;
        tick();
        while (busy === 1'b1 && guard < 300) begin
            if (busy_n < 64) begin
                tms_v[busy_n] = tms;
                tdi_v[busy_n] = tdi;
            end
            busy_n++;
            guard++;
            cmd_valid = (busy_n < exp_busy - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_op    = 2'($urandom);
            cmd_len   = LEN_W'($urandom);
            cmd_data  = $urandom;
            tick();
        end
        cmd_valid = 1'b0;
        check("busy_bound", 64'(guard < 300), 64'd1);
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] op, input int len,
                                 input logic [31:0] data, input bit tail,
                                 output int bn, output logic [63:0] tv);
        int n, eb;
        logic [63:0] et, ed, dv;
        logic [31:0] r, nr;
        n = clamp_len(len);
        expect_seq(op, n, data, eb, et, ed);
        do_cmd(op, len, data, eb, bn, tv, dv);
        if (op == OP_DR_SCAN) begin
            scan_model(exp_dr, dr_len, data, n, r, nr);
            exp_rsp = r;
            exp_dr  = nr;
        end else if (op == OP_IR_SCAN) begin
            scan_model(32'h1, 4, data, n, r, nr);
            exp_rsp = r;
            exp_ir  = nr;
        end
        check({tag, "_busy"}, 64'(bn), 64'(eb));
        check({tag, "_tms"}, tv, et);
        check({tag, "_tdi"}, dv, ed);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_tap"}, 64'(tap_state), 64'(RTI));
        check({tag, "_tgt_tap"}, 64'(tgt_tap), 64'(RTI));
        check({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp_rsp));
        if (op == OP_DR_SCAN) check({tag, "_tgt_dr"}, 64'(dr), 64'(exp_dr));
        if (op == OP_IR_SCAN) check({tag, "_tgt_ir"}, 64'(ir), 64'(exp_ir));
        if (tail) begin
            tick();
            check({tag, "_rsp_pulse"}, 64'(rsp_valid), 64'd0);
            check({tag, "_rsp_hold"}, 64'(rsp_data), 64'(exp_rsp));
        end
    endtask

    initial begin
        int          bn;
        logic [63:0] tv;
        logic        seen;
        logic [1:0]  op;

        RESET_N   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_len   = '0;
        cmd_data  = '0;

        // Reset values, then the INIT sequence after release
        repeat (2) tick();
        check("rst_tms", 64'(tms), 64'd1);
        check("rst_tdi", 64'(tdi), 64'd0);
        check("rst_ready", 64'(cmd_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_tap", 64'(tap_state), 64'(TLR));
        RESET_N = 1'b1;
        tv   = '0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tv[c] = tms;
            seen  = seen | cmd_ready;
            tick();
        end
        check("init_tms", tv, 64'b011111);
        check("init_early_ready", 64'(seen), 64'd0);
        check("init_ready7", 64'(cmd_ready), 64'd1);
        check("init_rsp_valid", 64'(rsp_valid), 64'd0);
        check("init_tap", 64'(tap_state), 64'(RTI));
        check("init_tgt_tap", 64'(tgt_tap), 64'(RTI));

        // DR scan, 8 bits through an 8-bit target DR
        preload_dr(8, 32'h3C);
        run_and_check("dr8", OP_DR_SCAN, 8, 32'hA5, 1'b1, bn, tv);
        check("dr8_busy13", 64'(bn), 64'd13);
        check("dr8_rsp3c", 64'(rsp_data), 64'h3C);
        check("dr8_tgt_a5", 64'(dr), 64'hA5);

        // IR scan, 4 bits
        run_and_check("ir4", OP_IR_SCAN, 4, 32'h9, 1'b1, bn, tv);
        check("ir4_tms_seq", tv, 64'h183);
        check("ir4_rsp1", 64'(rsp_data), 64'h1);
        check("ir4_tgt_9", 64'(ir), 64'h9);

        // IDLE then a DR scan accepted in the completion cycle
        preload_dr(12, 32'hABC);
        run_and_check("idle3", OP_IDLE, 3, 32'hFFFF_FFFF, 1'b0, bn, tv);
        check("idle3_busy3", 64'(bn), 64'd3);
        check("idle3_tms0", tv, 64'd0);
        check("idle3_rsp_kept", 64'(rsp_data), 64'h1);
        run_and_check("b2b_dr", OP_DR_SCAN, 5, 32'h15, 1'b1, bn, tv);
        check("b2b_busy10", 64'(bn), 64'd10);

        // Length clamping
        preload_dr(3, 32'h5);
        run_and_check("len0", OP_DR_SCAN, 0, 32'h1, 1'b1, bn, tv);
        check("len0_busy6", 64'(bn), 64'd6);
        preload_dr(32, 32'hDEAD_BEEF);
        run_and_check("len40", OP_DR_SCAN, 40, 32'h1234_5678, 1'b1, bn, tv);
        check("len40_busy37", 64'(bn), 64'd37);
        check("len40_rsp", 64'(rsp_data), 64'hDEAD_BEEF);

        // Randomized command mix
        for (int it = 0; it < 24; it++) begin
            op = 2'($urandom_range(0, 3));
            if (op == OP_DR_SCAN) preload_dr($urandom_range(1, 32), $urandom);
            run_and_check("rand", op, $urandom_range(0, 40), $urandom, 1'b1, bn, tv);
        end

        // Reset asserted during the third shift bit of a DR scan
        preload_dr(8, 32'h5A);
        cmd_valid = 1'b1;
        cmd_op    = OP_DR_SCAN;
        cmd_len   = LEN_W'(8);
        cmd_data  = 32'hFF;
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        check("abort_in_shift", 64'(tap_state), 64'(SH_DR));
        RESET_N = 1'b0;
        tick();
        exp_rsp = '0;
        check("abort_tms", 64'(tms), 64'd1);
        check("abort_tdi", 64'(tdi), 64'd0);
        check("abort_ready", 64'(cmd_ready), 64'd0);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_rsp_data", 64'(rsp_data), 64'd0);
        check("abort_tap", 64'(tap_state), 64'(TLR));
        RESET_N = 1'b1;
        tv   = '0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tv[c] = tms;
            seen  = seen | cmd_ready | rsp_valid;
            tick();
        end
        check("reinit_tms", tv, 64'b011111);
        check("reinit_quiet", 64'(seen), 64'd0);
        check("reinit_ready", 64'(cmd_ready), 64'd1);
        check("reinit_no_rsp", 64'(rsp_valid), 64'd0);
        check("reinit_tap", 64'(tap_state), 64'(RTI));
        check("reinit_tgt_tap", 64'(tgt_tap), 64'(RTI));

        preload_dr(8, 32'h81);
        run_and_check("post_abort", OP_DR_SCAN, 8, 32'h7E, 1'b1, bn, tv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
